cp0_irq_ctrl: RTL and testbench

CP0_IRQ_CTRL -- requirements
Module: cp0_irq_ctrl

---
 rtl/cp0_pkg.sv | 34 +++
 rtl/cp0_timer.sv | 50 +++++
 rtl/cp0_irq_ctrl.sv | 133 +++++++++++++
 tb/tb_cp0_irq_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// CP0 register numbers, Status/Cause field positions and exception codes
// shared by the interrupt controller and its optional timer.
package cp0_pkg;
   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_COUNT    = 5'd9;
   localparam logic [4:0] REG_COMPARE  = 5'd11;
   localparam logic [4:0] REG_SR       = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;
   localparam logic [4:0] REG_PRID     = 5'd15;

   localparam int SR_IE    = 0;
   localparam int SR_EXL   = 1;
   localparam int IM_LSB   = 10;
   localparam int IM7_BIT  = 15;
   localparam int CAUSE_BD = 31;
   localparam int CAUSE_TI = 30;
   localparam int IP_LSB   = 10;
   localparam int IP7_BIT  = 15;
   localparam int EXC_LSB  = 2;

   typedef enum logic [4:0] {
      EXC_INT     = 5'd0,
      EXC_ADEL    = 5'd4,
      EXC_ADES    = 5'd5,
      EXC_SYSCALL = 5'd8,
      EXC_RI      = 5'd10,
      EXC_OV      = 5'd12
   } exc_code_e;

   function automatic logic is_addr_exc(input logic [4:0] code);
      return (code == 5'(EXC_ADEL)) || (code == 5'(EXC_ADES));
   endfunction
endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with sticky TI flag; present only when CP0_TIMER_EN is defined.
// Count loads on mtc0 instead of incrementing; a Compare write clears TI ahead of a match.
`ifdef CP0_TIMER_EN
module cp0_timer
   import cp0_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        wr_en_i,
   input  logic [4:0]  wr_addr_i,
   input  logic [31:0] wr_data_i,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic        ti_o
);
   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic        ti_q, ti_d;
   logic        wr_count, wr_compare;

   assign wr_count   = wr_en_i && (wr_addr_i == REG_COUNT);
   assign wr_compare = wr_en_i && (wr_addr_i == REG_COMPARE);

   always_comb begin
      count_d   = wr_count ? wr_data_i : count_q + 32'd1;
      compare_d = wr_compare ? wr_data_i : compare_q;
      ti_d      = ti_q;
      if (wr_compare)
         ti_d = 1'b0;
      else if (count_q == compare_q)
         ti_d = 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q   <= '0;
         compare_q <= '0;
         ti_q      <= 1'b0;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
         ti_q      <= ti_d;
      end
   end

   assign count_o   = count_q;
   assign compare_o = compare_q;
   assign ti_o      = ti_q;
endmodule
`endif

// File: rtl/cp0_irq_ctrl.sv
// CP0 status/cause/EPC block: combinational read port and exception/interrupt request.
// Define CP0_TIMER_EN to build in the Count/Compare timer driving IP7.
module cp0_irq_ctrl
   import cp0_pkg::*;
#(
   parameter int          NUM_HWINT = 5,
   parameter logic [31:0] PRID_VAL  = 32'h0000_0C07
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [4:0]           rd_addr,
   input  logic [4:0]           wr_addr,
   input  logic                 wr_en,
   input  logic [31:0]          wr_data,
   input  logic [4:0]           exc_code_in,
   input  logic [31:0]          pc_m,
   input  logic                 bd_in,
   input  logic [31:0]          badvaddr_in,
   input  logic [NUM_HWINT-1:0] hw_int,
   input  logic                 eret,
   output logic [31:0]          rd_data,
   output logic [31:0]          epc_out,
   output logic                 req
);
   logic [NUM_HWINT-1:0] im_q, im_d, ip_q;
   logic                 im7_q, im7_d, exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
   logic [4:0]           exc_q, exc_d;
   logic [31:0]          epc_q, epc_d, bad_q, bad_d;
   logic [31:0]          count_val, compare_val, sr_word, cause_word;
   logic                 ti, int_req, exc_req;

`ifdef CP0_TIMER_EN
   cp0_timer u_timer (
      .clk_i     (clk),
      .rst_i     (reset),
      .wr_en_i   (wr_en & ~req),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .count_o   (count_val),
      .compare_o (compare_val),
      .ti_o      (ti)
   );
`else
   assign count_val   = '0;
   assign compare_val = '0;
   assign ti          = 1'b0;
`endif

   assign int_req = (|({ti, ip_q} & {im7_q, im_q})) & ie_q & ~exl_q;
   assign exc_req = (exc_code_in != 5'd0) & ~exl_q;
   // Gate with reset so a pending exc_code_in cannot raise req while held in reset.
   assign req     = ~reset & (int_req | exc_req);

   always_comb begin
      im_d  = im_q;
      im7_d = im7_q;
      exl_d = exl_q;
      ie_d  = ie_q;
      bd_d  = bd_q;
      exc_d = exc_q;
      epc_d = epc_q;
      bad_d = bad_q;
      if (req) begin
         exl_d = 1'b1;
         epc_d = (bd_in ? pc_m - 32'd4 : pc_m) & ~32'd3;
         bd_d  = bd_in;
         exc_d = int_req ? 5'(EXC_INT) : exc_code_in;
         if (!int_req && is_addr_exc(exc_code_in))
            bad_d = badvaddr_in;
      end else begin
         if (wr_en && (wr_addr == REG_SR)) begin
            im_d  = wr_data[IM_LSB +: NUM_HWINT];
            im7_d = wr_data[IM7_BIT];
            exl_d = wr_data[SR_EXL];
            ie_d  = wr_data[SR_IE];
         end
         if (wr_en && (wr_addr == REG_EPC))
            epc_d = wr_data;
         if (eret)
            exl_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         im_q  <= '0;
         im7_q <= 1'b0;
         exl_q <= 1'b0;
         ie_q  <= 1'b0;
         bd_q  <= 1'b0;
         exc_q <= '0;
         epc_q <= '0;
         bad_q <= '0;
         ip_q  <= '0;
      end else begin
         im_q  <= im_d;
         im7_q <= im7_d;
         exl_q <= exl_d;
         ie_q  <= ie_d;
         bd_q  <= bd_d;
         exc_q <= exc_d;
         epc_q <= epc_d;
         bad_q <= bad_d;
         ip_q  <= hw_int;
      end
   end

   always_comb begin
      sr_word                         = '0;
      sr_word[IM_LSB +: NUM_HWINT]    = im_q;
      sr_word[IM7_BIT]                = im7_q;
      sr_word[SR_EXL]                 = exl_q;
      sr_word[SR_IE]                  = ie_q;
      cause_word                      = '0;
      cause_word[CAUSE_BD]            = bd_q;
      cause_word[CAUSE_TI]            = ti;
      cause_word[IP_LSB +: NUM_HWINT] = ip_q;
      cause_word[IP7_BIT]             = ti;
      cause_word[EXC_LSB +: 5]        = exc_q;
      case (rd_addr)
         REG_BADVADDR: rd_data = bad_q;
         REG_COUNT:    rd_data = count_val;
         REG_COMPARE:  rd_data = compare_val;
         REG_SR:       rd_data = sr_word;
         REG_CAUSE:    rd_data = cause_word;
         REG_EPC:      rd_data = epc_q;
         REG_PRID:     rd_data = PRID_VAL;
         default:      rd_data = '0;
      endcase
   end

   assign epc_out = epc_q;
endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Directed scenarios followed by random traffic, every cycle checked against a word-level CP0 model.
module tb_cp0_irq_ctrl;
   localparam int          N       = 5;
   localparam logic [31:0] SR_MASK = 32'h0000_FC03;
   localparam logic [31:0] PRID    = 32'h0000_0C07;
`ifdef CP0_TIMER_EN
   localparam bit TMR = 1'b1;
`else
   localparam bit TMR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [4:0]    rd_addr, wr_addr, exc_code_in;
   logic          wr_en, bd_in, eret;
   logic [31:0]   wr_data, pc_m, badvaddr_in;
   logic [N-1:0]  hw_int;
   logic [31:0]   rd_data, epc_out;
   logic          req;

   int errors = 0;
   int checks = 0;

   logic [31:0]  m_sr, m_epc, m_bad, m_cnt, m_cmp;
   logic         m_bd, m_ti;
   logic [4:0]   m_exc;
   logic [N-1:0] m_ip;

   cp0_irq_ctrl dut (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .wr_addr(wr_addr),
      .wr_en(wr_en), .wr_data(wr_data), .exc_code_in(exc_code_in),
      .pc_m(pc_m), .bd_in(bd_in), .badvaddr_in(badvaddr_in),
      .hw_int(hw_int), .eret(eret), .rd_data(rd_data),
      .epc_out(epc_out), .req(req)
   );

   always #10 clk = ~clk;

   function automatic logic [31:0] m_cause();
      return ({31'b0, m_bd} << 31) | ({31'b0, m_ti} << 30) | ({31'b0, m_ti} << 15)
           | ({27'b0, m_ip} << 10) | ({27'b0, m_exc} << 2);
   endfunction

   function automatic logic m_int();
      logic [31:0] pend;
      pend = m_cause() & m_sr & 32'h0000_FF00;
      return (pend != 32'd0) && m_sr[0] && !m_sr[1];
   endfunction

   function automatic logic m_excr();
      return (exc_code_in != 5'd0) && !m_sr[1];
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd8:    return m_bad;
         5'd9:    return TMR ? m_cnt : 32'd0;
         5'd11:   return TMR ? m_cmp : 32'd0;
         5'd12:   return m_sr;
         5'd13:   return m_cause();
         5'd14:   return m_epc;
         5'd15:   return PRID;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_clear();
      m_sr = 0; m_epc = 0; m_bad = 0; m_cnt = 0; m_cmp = 0;
      m_bd = 0; m_ti = 0; m_exc = 0; m_ip = 0;
   endtask

   task automatic model_edge();
      logic ir, taken, match;
      ir    = m_int();
      taken = ir || m_excr();
      match = (m_cnt == m_cmp);
      if (taken) begin
         m_sr  = m_sr | 32'd2;
         m_epc = (bd_in ? pc_m - 32'd4 : pc_m) & ~32'd3;
         m_bd  = bd_in;
         m_exc = ir ? 5'd0 : exc_code_in;
         if (!ir && (exc_code_in == 5'd4 || exc_code_in == 5'd5)) m_bad = badvaddr_in;
      end else begin
         if (wr_en && wr_addr == 5'd12) m_sr = wr_data & SR_MASK;
         if (wr_en && wr_addr == 5'd14) m_epc = wr_data;
         if (eret) m_sr = m_sr & ~32'd2;
      end
      if (TMR) begin
         if (!taken && wr_en && wr_addr == 5'd11) begin
            m_cmp = wr_data;
            m_ti  = 1'b0;
         end else if (match) begin
            m_ti = 1'b1;
         end
         if (!taken && wr_en && wr_addr == 5'd9) m_cnt = wr_data;
         else m_cnt = m_cnt + 32'd1;
      end
      m_ip = hw_int;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] exp);
      rd_addr = a;
      #1;
      chk(tag, rd_data, exp);
   endtask

   // Checks outputs against the model, then advances DUT and model by one edge.
   task automatic cycle_chk();
      #2;
      chk("req", {31'b0, req}, {31'b0, (m_int() | m_excr())});
      chk("rd_data", rd_data, m_read(rd_addr));
      chk("epc_out", epc_out, m_epc);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      wr_en = 0; wr_addr = 0; wr_data = 0; exc_code_in = 0; eret = 0;
      bd_in = 0; pc_m = 0; badvaddr_in = 0; hw_int = 0; rd_addr = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      exc_code_in = 5'd5;
      #1;
      model_clear();
      chk("rst_req", {31'b0, req}, 32'd0);
      chk("rst_epc_out", epc_out, 32'd0);
      peek("rst_badvaddr", 5'd8, 32'd0);
      peek("rst_count", 5'd9, 32'd0);
      peek("rst_compare", 5'd11, 32'd0);
      peek("rst_sr", 5'd12, 32'd0);
      peek("rst_cause", 5'd13, 32'd0);
      peek("rst_epc", 5'd14, 32'd0);
      peek("rst_prid", 5'd15, PRID);
      @(posedge clk);
      #1;
      reset = 1'b0;
      exc_code_in = 5'd0;
   endtask

   logic [4:0] exc_list [8];
   logic [4:0] reg_list [8];

   initial begin
      exc_list = '{5'd0, 5'd0, 5'd0, 5'd4, 5'd5, 5'd8, 5'd10, 5'd12};
      reg_list = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
      reset = 1'b1;
      idle_inputs();
      model_clear();
      @(posedge clk);
      #1;
      do_reset();

      // Interrupt on IM0 with IE set
      wr_en = 1; wr_addr = 5'd12; wr_data = 32'h0000_0401; cycle_chk();
      wr_en = 0; hw_int = 5'b00001; pc_m = 32'h0000_1000; cycle_chk();
      rd_addr = 5'd12; #1;
      chk("int_req_asserted", {31'b0, req}, 32'd1);
      cycle_chk();
      peek("int_sr_exl", 5'd12, 32'h0000_0403);
      chk("int_exccode", {27'b0, rd_data[6:2]}, 32'd0);
      peek("int_cause", 5'd13, m_cause());
      chk("int_epc", epc_out, 32'h0000_1000);

      // AdEL in a delay slot
      hw_int = 0; eret = 1; cycle_chk();
      eret = 0; exc_code_in = 5'd4; bd_in = 1; pc_m = 32'h0000_3008; badvaddr_in = 32'h1;
      cycle_chk();
      idle_inputs();
      chk("adel_epc", epc_out, 32'h0000_3004);
      peek("adel_badvaddr", 5'd8, 32'h0000_0001);
      peek("adel_cause", 5'd13, 32'h8000_0010 | (TMR && m_ti ? 32'h4000_8000 : 32'h0));

      // Exception masked by EXL, then eret
      exc_code_in = 5'd12; pc_m = 32'h0000_5000; cycle_chk();
      chk("exl_epc_kept", epc_out, 32'h0000_3004);
      exc_code_in = 0; eret = 1; cycle_chk();
      eret = 0;
      peek("eret_sr", 5'd12, 32'h0000_0401);

      // Interrupt beats RI and same-cycle mtc0 EPC
      hw_int = 5'b00001; cycle_chk();
      exc_code_in = 5'd10; wr_en = 1; wr_addr = 5'd14; wr_data = 32'hDEAD_BEEF;
      pc_m = 32'h0000_2000; bd_in = 0;
      cycle_chk();
      idle_inputs();
      chk("prio_epc", epc_out, 32'h0000_2000);
      peek("prio_cause", 5'd13, m_cause());
      chk("prio_exccode", {27'b0, rd_data[6:2]}, 32'd0);

`ifdef CP0_TIMER_EN
      eret = 1; cycle_chk(); eret = 0;
      wr_en = 1; wr_addr = 5'd11; wr_data = 32'd10; cycle_chk();
      wr_addr = 5'd12; wr_data = 32'h0000_8001; cycle_chk();
      wr_addr = 5'd9; wr_data = 32'd0; cycle_chk();
      wr_en = 0;
      for (int i = 0; i < 30; i++) begin
         rd_addr = 5'd9; #1;
         if (req) break;
         cycle_chk();
      end
      chk("timer_req", {31'b0, req}, 32'd1);
      chk("timer_count_at_ti", rd_data, 32'd11);
      cycle_chk();
      wr_en = 1; wr_addr = 5'd11; wr_data = 32'd100; cycle_chk();
      wr_en = 0;
      peek("timer_ti_cleared", 5'd13, m_cause());
      chk("timer_ti_bit", {31'b0, rd_data[30]}, 32'd0);
      wr_en = 1; wr_addr = 5'd9; wr_data = 32'hFFFF_FFFF; cycle_chk();
      wr_en = 0;
      peek("count_full", 5'd9, 32'hFFFF_FFFF);
`else
      wr_en = 1; wr_addr = 5'd9; wr_data = 32'd5; cycle_chk();
      wr_addr = 5'd11; wr_data = 32'd7; cycle_chk();
      wr_en = 0;
      peek("notimer_count", 5'd9, 32'd0);
      peek("notimer_compare", 5'd11, 32'd0);
`endif
      peek("pre_reset_sr_exl", 5'd12, m_sr);
      chk("pre_reset_exl_set", {31'b0, rd_data[1]}, 32'd1);
      do_reset();

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 79) == 0) begin
            do_reset();
         end else begin
            wr_en       = ($urandom_range(0, 3) == 0);
            wr_addr     = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31))
                                                       : reg_list[$urandom_range(0, 7)];
            wr_data     = $urandom;
            exc_code_in = exc_list[$urandom_range(0, 7)];
            eret        = ($urandom_range(0, 7) == 0);
            bd_in       = 1'($urandom_range(0, 1));
            pc_m        = $urandom;
            badvaddr_in = $urandom;
            hw_int      = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            rd_addr     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                       : reg_list[$urandom_range(0, 7)];
            cycle_chk();
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
